// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared types and source indices for the LC-3 bus gate arbiter.
// Imported by the interface, the picker and the arbiter top.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } arb_state_t;

  localparam int SRC_ALU    = 0;
  localparam int SRC_PC     = 1;
  localparam int SRC_MARMUX = 2;
  localparam int SRC_MDR    = 3;
  localparam int NUM_SRC    = 4;

endpackage

// File: rtl/bus_gate_arbiter_if.sv
// bus_gate_arbiter_if: request/gate bundle between bus sources and arbiter.
// master = requesting side, slave = arbiter side.
interface bus_gate_arbiter_if;
  import bus_arb_pkg::*;

  logic [NUM_SRC-1:0] req;
  logic               GateALU;
  logic               GatePC;
  logic               GateMARMUX;
  logic               GateMDR;
  logic [1:0]         owner;
  logic               busy;
  logic               timeout;

  modport master (
    output req,
    input  GateALU,
    input  GatePC,
    input  GateMARMUX,
    input  GateMDR,
    input  owner,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output GateALU,
    output GatePC,
    output GateMARMUX,
    output GateMDR,
    output owner,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_pick4.sv
// rr_pick4: 4-way rotate-priority encoder.
// Searches upward from ptr+1; ptr itself has lowest priority.
module rr_pick4
  import bus_arb_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         ptr,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  always_comb begin
    valid = |req;
    idx   = '0;
    cand  = '0;
    // Walk from farthest to nearest so the nearest hit wins.
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter: round-robin owner of the four LC-3 bus gate enables.
// Define BUS_ARB_TIMEOUT_EN to revoke grants held beyond MAX_HOLD cycles.
module bus_gate_arbiter
  import bus_arb_pkg::*;
#(
  parameter int TURN_CYCLES = 1,
  parameter int MAX_HOLD    = 8
) (
  input logic               Clk,
  input logic               Reset,
  bus_gate_arbiter_if.slave bus
);

  localparam int TW =
    (TURN_CYCLES > 0) ? $clog2(TURN_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TURN_LD = TW'(TURN_CYCLES);

  arb_state_t         state, state_n;
  logic [NUM_SRC-1:0] gates, gates_n;
  logic [NUM_SRC-1:0] mask;
  logic [1:0]         owner, owner_n;
  logic [1:0]         ptr, ptr_n;
  logic [TW-1:0]      tcnt, tcnt_n;
  logic               busy;
  logic               hold_hit;
  logic               pick_v;
  logic [1:0]         pick_idx;

  rr_pick4 u_pick (
    .req   (bus.req & ~mask),
    .ptr   (ptr),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  always_comb begin
    state_n = state;
    gates_n = gates;
    owner_n = owner;
    ptr_n   = ptr;
    tcnt_n  = tcnt;
    unique case (state)
      IDLE: begin
        gates_n = '0;
        if (pick_v) begin
          state_n = GRANT;
          gates_n = NUM_SRC'(1) << pick_idx;
          owner_n = pick_idx;
          ptr_n   = pick_idx;
        end
      end
      GRANT: begin
        if (!bus.req[owner] || hold_hit) begin
          gates_n = '0;
          if (TURN_CYCLES > 0 || hold_hit) begin
            state_n = TURN;
            tcnt_n  = TURN_LD;
          end else begin
            state_n = IDLE;
          end
        end
      end
      TURN: begin
        gates_n = '0;
        if (tcnt <= TW'(1)) state_n = IDLE;
        else tcnt_n = tcnt - TW'(1);
      end
      default: begin
        state_n = IDLE;
        gates_n = '0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      gates <= '0;
      owner <= '0;
      ptr   <= 2'd3;
      tcnt  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      gates <= gates_n;
      owner <= owner_n;
      ptr   <= ptr_n;
      tcnt  <= tcnt_n;
      busy  <= (state_n != IDLE);
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [HW-1:0] hcnt;
  logic          revoke;
  logic          timeout;

  assign hold_hit = (hcnt >= HOLD_MAX);
  assign revoke   = (state == GRANT) && bus.req[owner] && hold_hit;

  // hcnt counts gate-high cycles of the current grant, starting at 1.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hcnt    <= '0;
      mask    <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= revoke;
      mask    <= (mask & bus.req) |
                 (revoke ? (NUM_SRC'(1) << owner) : '0);
      if (state_n != GRANT)     hcnt <= '0;
      else if (state != GRANT)  hcnt <= HW'(1);
      else if (hcnt < HOLD_MAX) hcnt <= hcnt + HW'(1);
    end
  end

  assign bus.timeout = timeout;
`else
  assign hold_hit    = 1'b0;
  assign mask        = '0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.GateALU    = gates[SRC_ALU];
  assign bus.GatePC     = gates[SRC_PC];
  assign bus.GateMARMUX = gates[SRC_MARMUX];
  assign bus.GateMDR    = gates[SRC_MDR];
  assign bus.owner      = owner;
  assign bus.busy       = busy;

endmodule
